// File: rtl/lift_scan_scheduler.sv
// lift_scan_scheduler: SCAN-order scheduler for one elevator car with
// floor-to-floor travel pacing, door dwell and an overweight door hold.
module lift_scan_scheduler #(
    parameter int FLOORS       = 8,
    parameter int TRAVEL_CYC   = 4,
    parameter int DOOR_CYC     = 6,
    parameter int WEIGHT_LIMIT = 899
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic [2:0]  req_floor_i,
    input  logic [10:0] weight_i,
    output logic [2:0]  out_floor_o,
    output logic [1:0]  direction_o,
    output logic        door_open_o,
    output logic        complete_o,
    output logic        over_weight_o,
    output logic [7:0]  pending_o
);
    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_e;

    localparam logic [1:0]  DIR_NONE  = 2'd0;
    localparam logic [1:0]  DIR_UP    = 2'd1;
    localparam logic [1:0]  DIR_DN    = 2'd2;
    localparam logic [7:0]  TRAVEL_LD = 8'(TRAVEL_CYC - 1);
    localparam logic [7:0]  DOOR_LD   = 8'(DOOR_CYC - 1);
    localparam logic [3:0]  FLOOR_CNT = 4'(FLOORS);
    localparam logic [10:0] WLIM      = 11'(WEIGHT_LIMIT);

    state_e      state_q, state_d;
    logic [2:0]  floor_q, floor_d;
    logic [1:0]  dir_q, dir_d;
    logic        last_up_q, last_up_d;
    logic        door_q, door_d;
    logic        cmpl_q, cmpl_d;
    logic        ow_q, ow_d;
    logic [7:0]  pend_q, pend_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [7:0]  dcnt_q, dcnt_d;

    logic        ahead_up, ahead_dn, go_up;
    logic        req_ok, same_req, arrive;
    logic [2:0]  step_floor;

    always_comb begin
        ahead_up = 1'b0;
        ahead_dn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (pend_q[i] && (i > int'(floor_q))) ahead_up = 1'b1;
            if (pend_q[i] && (i < int'(floor_q))) ahead_dn = 1'b1;
        end
    end

    // Keep sweeping in last_dir while anything lies ahead, else reverse.
    assign go_up      = last_up_q ? ahead_up : !ahead_dn;
    assign step_floor = (dir_q == DIR_UP) ? floor_q + 3'd1 : floor_q - 3'd1;
    assign req_ok     = req_valid_i && ({1'b0, req_floor_i} < FLOOR_CNT);
    assign same_req   = req_ok && (state_q == S_DOOR) && (req_floor_i == floor_q);
    assign arrive     = (tcnt_q == '0) && pend_q[step_floor];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            floor_q   <= '0;
            dir_q     <= DIR_NONE;
            last_up_q <= 1'b1;
            door_q    <= 1'b0;
            cmpl_q    <= 1'b0;
            ow_q      <= 1'b0;
            pend_q    <= '0;
            tcnt_q    <= '0;
            dcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            last_up_q <= last_up_d;
            door_q    <= door_d;
            cmpl_q    <= cmpl_d;
            ow_q      <= ow_d;
            pend_q    <= pend_d;
            tcnt_q    <= tcnt_d;
            dcnt_q    <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (pend_q[floor_q])          state_d = S_DOOR;
                else if (ahead_up || ahead_dn) state_d = S_MOVE;
            end
            S_MOVE: if (arrive) state_d = S_DOOR;
            S_DOOR: begin
                if (!same_req && !ow_q && (dcnt_q == '0)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        floor_d   = floor_q;
        dir_d     = dir_q;
        last_up_d = last_up_q;
        door_d    = door_q;
        cmpl_d    = 1'b0;
        ow_d      = weight_i > WLIM;
        pend_d    = pend_q;
        tcnt_d    = tcnt_q;
        dcnt_d    = dcnt_q;
        if (req_ok && !same_req) pend_d[req_floor_i] = 1'b1;
        // Service clears after capture so a same-edge request is absorbed.
        unique case (state_q)
            S_IDLE: begin
                dir_d = DIR_NONE;
                if (state_d == S_DOOR) begin
                    door_d          = 1'b1;
                    cmpl_d          = 1'b1;
                    dcnt_d          = DOOR_LD;
                    pend_d[floor_q] = 1'b0;
                end else if (state_d == S_MOVE) begin
                    dir_d     = go_up ? DIR_UP : DIR_DN;
                    last_up_d = go_up;
                    tcnt_d    = TRAVEL_LD;
                end
            end
            S_MOVE: begin
                if (tcnt_q == '0) begin
                    floor_d = step_floor;
                    tcnt_d  = TRAVEL_LD;
                    if (arrive) begin
                        door_d             = 1'b1;
                        cmpl_d             = 1'b1;
                        dcnt_d             = DOOR_LD;
                        pend_d[step_floor] = 1'b0;
                    end
                end else begin
                    tcnt_d = tcnt_q - 8'd1;
                end
            end
            S_DOOR: begin
                if (same_req || ow_q) begin
                    dcnt_d = DOOR_LD;
                end else if (dcnt_q == '0) begin
                    door_d = 1'b0;
                    dir_d  = DIR_NONE;
                end else begin
                    dcnt_d = dcnt_q - 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign out_floor_o   = floor_q;
    assign direction_o   = dir_q;
    assign door_open_o   = door_q;
    assign complete_o    = cmpl_q;
    assign over_weight_o = ow_q;
    assign pending_o     = pend_q;

endmodule

// File: doc/lift_scan_scheduler.md
# lift_scan_scheduler

Sequencing controller for a single elevator car. It latches floor requests into a pending bitmap and schedules them in SCAN order: the car serves every request in its current direction of travel before it reverses. It also paces floor-to-floor travel with a travel timer, runs a door dwell timer, and holds the door open while the car is overweight. It sits between the request inputs (car and hall buttons) and the motor/door drivers, and replaces ad-hoc request scanning with one clocked scheduler.

## Interface
- FLOORS, 8, number of floors served (floors 0..FLOORS-1, max 8)
- TRAVEL_CYC, 4, clock cycles to move one floor (≥2)
- DOOR_CYC, 6, clock cycles the door stays open per stop (≥2)
- WEIGHT_LIMIT, 899, load above this value is overweight
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  qualifies req_floor this cycle
- req_floor  in  3  requested floor
- weight  in  11  current car load, unsigned
- out_floor  out  3  current floor of the car
- direction  out  2  0 = idle, 1 = up, 2 = down (3 is never driven)
- door_open  out  1  door-open command
- complete  out  1  one-cycle pulse when a pending request is served
- over_weight  out  1  registered (weight > WEIGHT_LIMIT)
- pending  out  8  outstanding request bitmap; bit f = floor f

## Operation
- States: IDLE, MOVE, DOOR. Internal registers: last_dir (1 bit, reset = up), travel counter, dwell counter.
- Reset values: state IDLE, out_floor 0, direction 0, door_open 0, complete 0, over_weight 0, pending 0, last_dir up.
- Request capture: when req_valid = 1 and req_floor < FLOORS, set pending[req_floor] on the next edge. Requests with req_floor ≥ FLOORS are ignored.
  - Exception: if the request is for out_floor while the state is DOOR, no bit is set; the dwell counter reloads instead.
- Notation: ahead_up = any pending bit above out_floor; ahead_dn = any pending bit below out_floor.
- IDLE evaluates the registered pending bitmap. Priority:
  1. pending[out_floor] set: go to DOOR.
  2. Requests ahead in last_dir: go to MOVE in last_dir.
  3. Requests in the opposite direction: go to MOVE in the opposite direction and update last_dir.
  4. Otherwise: stay in IDLE with direction = 0.
- MOVE:
  - direction is held at 1 or 2. The travel counter loads TRAVEL_CYC-1 on entry and decrements each cycle.
  - When the counter reaches 0, out_floor steps ±1 on that edge.
  - If the new floor has its pending bit set, the same edge enters DOOR. Otherwise the counter reloads and MOVE continues. Bits are only cleared by service, so requests always remain ahead.
- DOOR:
  - On entry: door_open = 1, pending[out_floor] cleared, complete pulses high for exactly one cycle, dwell counter loads DOOR_CYC-1.
  - direction keeps its travel value during DOOR. Entry from IDLE at the current floor leaves direction = 0.
  - The dwell counter decrements only while over_weight = 0. While over_weight = 1 it holds at DOOR_CYC-1.
  - When the counter reaches 0 with over_weight = 0: door_open = 0 and the state returns to IDLE on the same edge.
- over_weight is updated every cycle in every state. It affects only the dwell counter; the car never leaves DOOR while it is high.
- Reset asserted in any state, including mid-MOVE or mid-DOOR, forces all reset values on that edge and discards pending requests.

## Timing
- Request to pending bit: 1 cycle.
- Pending bit to first state change: 1 more cycle, evaluated from IDLE.
- Travel: TRAVEL_CYC cycles per floor, measured from MOVE entry to the out_floor update.
- Arrival: out_floor update, door_open rising and complete pulse all occur on the same edge.
- Door: door_open stays high for exactly DOOR_CYC cycles when not overweight. One IDLE cycle follows before any new MOVE.
- A request for out_floor during DOOR restarts the dwell: door_open stays high DOOR_CYC cycles after the request edge, with no second complete pulse.
- A request for out_floor during MOVE is set in pending. It is served after the current sweep, on the return.
- over_weight lags weight by 1 cycle. The door closes DOOR_CYC cycles after over_weight falls.

## Test plan
- Single trip: reset, then req 3 at cycle 0.
  - pending = 0x08 at cycle 1; MOVE with direction = 1 at cycle 2.
  - out_floor = 1 at cycle 6, 2 at cycle 10, 3 at cycle 14, with door_open and complete rising at cycle 14.
  - door_open low at cycle 20, then direction = 0.
- SCAN order: car at 0, req 5. While moving, req 2 and req 7.
  - Stops in order 2, 5, 7, with one complete pulse each.
  - A req 1 issued during the stop at 7 is served only after 7, with direction = 2.
- Overweight hold: during a stop at floor 2, drive weight = 900.
  - over_weight = 1 next cycle; door stays open for 50+ cycles.
  - Drive weight = 899: over_weight falls next cycle and door_open falls 6 cycles after that.
- Same-floor request during DOOR: at floor 4 with the door open, req 4.
  - Dwell restarts; no complete pulse; pending[4] stays 0.
- Idle same-floor request: car idle at 0, req 0.
  - door_open and complete at cycle 2; direction stays 0 throughout.
- Reset mid-MOVE: rst high while travelling 1 → 2 with pending = 0xA0.
  - Next edge: out_floor 0, direction 0, pending 0, door_open 0, complete 0.
